// File: rtl/control_hazard_vec.sv
// Front-end pipeline sequencer: load-use bubbles, multi-cycle vector op holds
// and taken-branch flushes for the PC, IF/ID and ID/EX registers.
`timescale 1ns/1ps
module control_hazard_vec #(
    parameter int REG_AW = 3,
    parameter int VLEN   = 4,
    parameter int CNT_W  = 16,
    localparam int EW    = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_used,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic              id_src_vec,
    input  logic              id_vec_op,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rd_vec,
    input  logic              ex_load,
    input  logic              mem_branch_taken,
    input  logic              stat_clr,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_bubble,
    output logic              vec_busy,
    output logic [EW-1:0]     elem_idx,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {ST_RUN, ST_VEC} state_t;

    localparam logic [EW-1:0] ELEM_LAST = EW'(VLEN - 1);
    localparam logic          VEC_MULTI = (VLEN > 1);

    state_t           r_state;
    logic [EW-1:0]    r_elem_idx;
    logic [CNT_W-1:0] r_stall_count;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_haz;
    logic w_vec_issue;

    assign w_rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
    assign w_rs2_hit = id_rs2_used && (id_rs2 == ex_rd);
    assign w_haz     = id_valid && ex_load && (ex_rd_vec == id_src_vec) && (w_rs1_hit || w_rs2_hit);

    // A vector op leaves element 0 in the issue cycle; only the remaining
    // elements need the front end held.
    assign w_vec_issue = (r_state == ST_RUN) && !mem_branch_taken && !w_haz &&
                         id_valid && id_vec_op && VEC_MULTI;

    // NOTE: every output gets a default first so no path through the
    // if/else chain can leave one unassigned and infer a latch.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
        vec_busy    = 1'b0;
        if (!reset_n) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_branch_taken) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
            vec_busy    = (r_state == ST_VEC);
        end else if (r_state == ST_VEC) begin
            vec_busy    = 1'b1;
        end else if (w_haz) begin
            idex_en     = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_elem_idx <= '0;
        end else if (mem_branch_taken) begin
            r_state    <= ST_RUN;
            r_elem_idx <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_vec_issue) begin
                        r_state    <= ST_VEC;
                        r_elem_idx <= EW'(1);
                    end
                end
                ST_VEC: begin
                    if (r_elem_idx == ELEM_LAST) begin
                        r_state    <= ST_RUN;
                        r_elem_idx <= '0;
                    end else begin
                        r_elem_idx <= r_elem_idx + EW'(1);
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_elem_idx <= '0;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle stall; the count sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_count <= '0;
        end else if (stat_clr) begin
            r_stall_count <= '0;
        end else if (!pc_en && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign elem_idx    = r_elem_idx;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_control_hazard_vec.sv
// Self-checking bench for control_hazard_vec: vector table driven through a
// scoreboard queue, plus hand-written saturation, vector and reset sequences.
`timescale 1ns/1ps
module tb_control_hazard_vec;

    localparam logic [5:0] N  = 6'b110100;
    localparam logic [5:0] H  = 6'b000110;
    localparam logic [5:0] V  = 6'b000001;
    localparam logic [5:0] B  = 6'b111110;
    localparam logic [5:0] BV = 6'b111111;
    localparam logic [5:0] R  = 6'b001010;

    typedef struct {
        logic       id_valid;
        logic [2:0] id_rs1;
        logic       rs1_used;
        logic [2:0] id_rs2;
        logic       rs2_used;
        logic       src_vec;
        logic       vec_op;
        logic [2:0] ex_rd;
        logic       ex_rd_vec;
        logic       ex_load;
        logic       br;
        logic       clr;
        logic [5:0] exp_o;
        logic [1:0] exp_idx;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       id_src_vec = 1'b0, id_vec_op = 1'b0, ex_rd_vec = 1'b0, ex_load = 1'b0;
    logic       mem_branch_taken = 1'b0, stat_clr = 1'b0;
    logic [2:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;

    logic        a_pc, a_ifid, a_flush, a_idex, a_bub, a_busy;
    logic [1:0]  a_idx;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifid, b_flush, b_idex, b_bub, b_busy;
    logic [1:0]  b_idx;
    logic [3:0]  b_cnt;
    logic        c_pc, c_ifid, c_flush, c_idex, c_bub, c_busy;
    logic [0:0]  c_idx;
    logic [15:0] c_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;
    vec_t tbl[24];
    vec_t sb[$];

    always #5 clk = ~clk;

    control_hazard_vec #(.REG_AW(3), .VLEN(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_src_vec(id_src_vec), .id_vec_op(id_vec_op), .ex_rd(ex_rd), .ex_rd_vec(ex_rd_vec),
        .ex_load(ex_load), .mem_branch_taken(mem_branch_taken), .stat_clr(stat_clr),
        .pc_en(a_pc), .ifid_en(a_ifid), .ifid_flush(a_flush), .idex_en(a_idex),
        .idex_bubble(a_bub), .vec_busy(a_busy), .elem_idx(a_idx), .stall_count(a_cnt));

    control_hazard_vec #(.REG_AW(3), .VLEN(4), .CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_src_vec(id_src_vec), .id_vec_op(id_vec_op), .ex_rd(ex_rd), .ex_rd_vec(ex_rd_vec),
        .ex_load(ex_load), .mem_branch_taken(mem_branch_taken), .stat_clr(stat_clr),
        .pc_en(b_pc), .ifid_en(b_ifid), .ifid_flush(b_flush), .idex_en(b_idex),
        .idex_bubble(b_bub), .vec_busy(b_busy), .elem_idx(b_idx), .stall_count(b_cnt));

    control_hazard_vec #(.REG_AW(3), .VLEN(1), .CNT_W(16)) dut_v1 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_src_vec(id_src_vec), .id_vec_op(id_vec_op), .ex_rd(ex_rd), .ex_rd_vec(ex_rd_vec),
        .ex_load(ex_load), .mem_branch_taken(mem_branch_taken), .stat_clr(stat_clr),
        .pc_en(c_pc), .ifid_en(c_ifid), .ifid_flush(c_flush), .idex_en(c_idex),
        .idex_bubble(c_bub), .vec_busy(c_busy), .elem_idx(c_idx), .stall_count(c_cnt));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [2:0] r1, input logic u1,
                                input logic [2:0] r2, input logic u2, input logic sv,
                                input logic vop, input logic [2:0] rd, input logic rdv,
                                input logic ld, input logic br, input logic clr,
                                input logic [5:0] eo, input logic [1:0] ei);
        vec_t t;
        t.id_valid = v;  t.id_rs1 = r1; t.rs1_used = u1; t.id_rs2 = r2; t.rs2_used = u2;
        t.src_vec = sv;  t.vec_op = vop; t.ex_rd = rd;   t.ex_rd_vec = rdv; t.ex_load = ld;
        t.br = br;       t.clr = clr;    t.exp_o = eo;   t.exp_idx = ei;
        return t;
    endfunction

    function automatic vec_t idle(input logic clr, input logic [5:0] eo, input logic [1:0] ei);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, clr, eo, ei);
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.id_valid; id_rs1 = v.id_rs1; id_rs1_used = v.rs1_used;
        id_rs2 = v.id_rs2;     id_rs2_used = v.rs2_used; id_src_vec = v.src_vec;
        id_vec_op = v.vec_op;  ex_rd = v.ex_rd; ex_rd_vec = v.ex_rd_vec;
        ex_load = v.ex_load;   mem_branch_taken = v.br; stat_clr = v.clr;
    endtask

    // One clock: drive, queue the expectation, compare mid-cycle, then advance
    // the stall-count model across the rising edge.
    task automatic step(input vec_t v);
        vec_t e;
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        check("outputs", {26'd0, a_pc, a_ifid, a_flush, a_idex, a_bub, a_busy}, {26'd0, e.exp_o});
        check("outputs_sat", {26'd0, b_pc, b_ifid, b_flush, b_idex, b_bub, b_busy}, {26'd0, e.exp_o});
        check("elem_idx", {30'd0, a_idx}, {30'd0, e.exp_idx});
        check("stall_count", {16'd0, a_cnt}, exp_cnt);
        check("stall_count_sat", {28'd0, b_cnt}, (exp_cnt > 15) ? 15 : exp_cnt);
        if (e.clr) exp_cnt = 0;
        else if (!e.exp_o[5]) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_v1(input string name);
        check(name, {26'd0, c_pc, c_ifid, c_flush, c_idex, c_bub, c_busy}, {26'd0, N});
        check({name, "_idx"}, {31'd0, c_idx}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // fields: valid rs1 u1 rs2 u2 src_vec vec_op ex_rd ex_vec ex_load br clr | exp elem
        tbl[0]  = idle(0, N, 0);
        tbl[1]  = mk(1, 1, 1, 2, 1, 0, 0, 3, 0, 0, 0, 0, N, 0);
        tbl[2]  = mk(1, 1, 1, 3, 1, 0, 0, 3, 0, 1, 0, 0, H, 0);
        tbl[3]  = mk(1, 1, 1, 3, 1, 0, 0, 3, 0, 0, 0, 0, N, 0);
        tbl[4]  = mk(1, 3, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, N, 0);
        tbl[5]  = mk(1, 3, 1, 0, 0, 1, 0, 3, 1, 1, 0, 0, H, 0);
        tbl[6]  = mk(1, 3, 0, 5, 1, 0, 0, 3, 0, 1, 0, 0, N, 0);
        tbl[7]  = mk(0, 3, 1, 3, 1, 0, 0, 3, 0, 1, 0, 0, N, 0);
        tbl[8]  = mk(1, 1, 1, 2, 1, 1, 1, 7, 0, 0, 0, 0, N, 0);
        tbl[9]  = idle(0, V, 1);
        tbl[10] = mk(1, 3, 1, 0, 0, 0, 0, 3, 0, 1, 0, 0, V, 2);
        tbl[11] = idle(0, V, 3);
        tbl[12] = idle(0, N, 0);
        tbl[13] = mk(1, 4, 1, 0, 0, 1, 1, 4, 1, 1, 0, 0, H, 0);
        tbl[14] = mk(1, 4, 1, 0, 0, 1, 1, 4, 1, 0, 0, 0, N, 0);
        tbl[15] = idle(0, V, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, BV, 2);
        tbl[17] = idle(0, N, 0);
        tbl[18] = mk(1, 1, 1, 3, 1, 0, 0, 3, 0, 1, 1, 0, B, 0);
        tbl[19] = idle(1, N, 0);
        tbl[20] = mk(1, 1, 1, 3, 1, 0, 0, 3, 0, 1, 0, 1, H, 0);
        tbl[21] = idle(0, N, 0);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, N, 0);
        tbl[23] = idle(0, N, 0);

        #1;
        check("reset_outputs", {26'd0, a_pc, a_ifid, a_flush, a_idex, a_bub, a_busy}, {26'd0, R});
        check("reset_outputs_sat", {26'd0, b_pc, b_ifid, b_flush, b_idex, b_bub, b_busy}, {26'd0, R});
        check("reset_outputs_v1", {26'd0, c_pc, c_ifid, c_flush, c_idex, c_bub, c_busy}, {26'd0, R});
        check("reset_state", {a_cnt, b_cnt, c_cnt[3:0], 2'd0, a_idx, b_idx, c_idx, 1'b0}, 32'd0);
        check("reset_count_v1", {16'd0, c_cnt}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_cnt = 0;

        for (int i = 0; i < 24; i++) step(tbl[i]);

        // Saturation of the 4-bit counter.
        step(idle(1, N, 0));
        for (int i = 0; i < 20; i++) step(mk(1, 1, 1, 3, 1, 0, 0, 3, 0, 1, 0, 0, H, 0));
        step(idle(0, N, 0));
        check("sat_hold_15", {28'd0, b_cnt}, 32'd15);
        step(idle(1, N, 0));
        step(idle(0, N, 0));
        check("sat_cleared", {28'd0, b_cnt}, 32'd0);

        // Full vector op: three stall cycles; VLEN=1 copy never stalls.
        step(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, N, 0));
        check_v1("v1_after_issue");
        step(idle(0, V, 1));
        check_v1("v1_no_vec");
        step(idle(0, V, 2));
        step(idle(0, V, 3));
        step(idle(0, N, 0));
        check("vec_stall_3", {16'd0, a_cnt}, 32'd3);

        // Reset asserted mid-VEC at elem_idx 2.
        step(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, N, 0));
        step(idle(0, V, 1));
        check("pre_reset_idx", {30'd0, a_idx}, 32'd2);
        reset_n = 1'b0;
        #1;
        check("midvec_reset_outputs", {26'd0, a_pc, a_ifid, a_flush, a_idex, a_bub, a_busy}, {26'd0, R});
        check("midvec_reset_idx", {30'd0, a_idx}, 32'd0);
        check("midvec_reset_count", {16'd0, a_cnt}, 32'd0);
        #2;
        reset_n = 1'b1;
        exp_cnt = 0;
        #1;
        check("release_pc_en", {31'd0, a_pc}, 32'd1);
        @(posedge clk);
        #1;
        step(idle(0, N, 0));

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
